// File: rtl/vgroup_sequencer.sv
// vgroup_sequencer: splits one vector instruction into per-register micro-ops over its LMUL group
module vgroup_sequencer #(
    parameter int VLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] in_raA,
    input  logic [$clog2(NREGS)-1:0] in_raB,
    input  logic [$clog2(NREGS)-1:0] in_wa,
    input  logic [2:0]               in_sew_enc,
    input  logic [2:0]               in_lmul_enc,
    input  logic [7:0]               in_vl,
    output logic                     uop_valid,
    input  logic                     uop_ready,
    output logic [$clog2(NREGS)-1:0] uop_raA,
    output logic [$clog2(NREGS)-1:0] uop_raB,
    output logic [$clog2(NREGS)-1:0] uop_wa,
    output logic [3:0]               uop_elem_cnt,
    output logic                     uop_first,
    output logic                     uop_last,
    output logic                     done,
    output logic                     err,
    output logic                     busy
);
    localparam int RW = $clog2(NREGS);
    localparam logic [7:0] EPR_MAX = 8'(VLEN / 8);

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nx;

    logic [1:0]    g_log;
    logic [RW-1:0] mask;
    logic [7:0]    epr_in, vlmax, eff_vl, rem, epr, cnt;
    logic          bad, accept, hs, last, first;

    // fractional LMUL occupies a single register
    assign g_log  = in_lmul_enc[2] ? 2'd0 : in_lmul_enc[1:0];
    assign mask   = (RW'(1) << g_log) - RW'(1);
    assign epr_in = EPR_MAX >> in_sew_enc[1:0];
    assign vlmax  = epr_in << g_log;
    assign eff_vl = in_vl < vlmax ? in_vl : vlmax;
    assign bad    = in_sew_enc[2] || in_lmul_enc == 3'd4 || |((in_raA | in_raB | in_wa) & mask);
    assign accept = in_valid && in_ready;
    assign cnt    = rem < epr ? rem : epr;
    assign last   = rem <= epr;
    assign hs     = uop_valid && uop_ready;

    assign in_ready     = state == IDLE;
    assign busy         = state == ISSUE;
    assign uop_valid    = state == ISSUE;
    assign uop_elem_cnt = uop_valid ? 4'(cnt) : 4'd0;
    assign uop_last     = uop_valid && last;
    assign uop_first    = uop_valid && first;

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = accept && !bad && eff_vl != 8'd0 ? ISSUE : IDLE;
        else
            state_nx = hs && last ? IDLE : ISSUE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            uop_raA <= '0;
            uop_raB <= '0;
            uop_wa  <= '0;
            rem     <= '0;
            epr     <= '0;
            first   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            err   <= 1'b0;
            if (accept) begin
                if (bad)
                    err <= 1'b1;
                else if (eff_vl == 8'd0)
                    done <= 1'b1;
                else begin
                    uop_raA <= in_raA;
                    uop_raB <= in_raB;
                    uop_wa  <= in_wa;
                    rem     <= eff_vl;
                    epr     <= epr_in;
                    first   <= 1'b1;
                end
            end
            if (hs) begin
                uop_raA <= uop_raA + RW'(1);
                uop_raB <= uop_raB + RW'(1);
                uop_wa  <= uop_wa + RW'(1);
                rem     <= rem - cnt;
                first   <= 1'b0;
                done    <= last;
            end
        end
    end
endmodule

// File: doc/vgroup_sequencer.md
Name: vgroup_sequencer

Overview:
- Issue-stage controller between vtype/vl configuration and the vRegFile/vALU pipe.
- Accepts one vector instruction at a time: base register numbers, encoded SEW/LMUL and vl.
- Breaks it into one micro-op per physical register of the LMUL group, each with per-register element count and first/last tags.
- Replaces single-step grouping selection with a valid/ready sequenced issue that tolerates downstream stalls.

Parameters:
- VLEN, 64, bits per vector register (elements per register = VLEN/SEW).
- NREGS, 32, number of architectural vector registers.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  sequencer can accept an instruction.
- in_raA  input  5  base source A register.
- in_raB  input  5  base source B register.
- in_wa  input  5  base destination register.
- in_sew_enc  input  3  encoded SEW: 0=8, 1=16, 2=32, 3=64; 4-7 illegal.
- in_lmul_enc  input  3  encoded LMUL: 0=1, 1=2, 2=4, 3=8, 5/6/7 fractional (treated as 1 register), 4 illegal.
- in_vl  input  8  requested element count.
- uop_valid  output  1  micro-op valid.
- uop_ready  input  1  downstream accepts micro-op.
- uop_raA  output  5  source A register for this micro-op.
- uop_raB  output  5  source B register for this micro-op.
- uop_wa  output  5  destination register for this micro-op.
- uop_elem_cnt  output  4  active elements in this register (1..8).
- uop_first  output  1  first micro-op of the instruction.
- uop_last  output  1  last micro-op of the instruction.
- done  output  1  one-cycle pulse: instruction fully issued.
- err  output  1  one-cycle pulse: instruction rejected.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - uop_valid, done, err, busy, uop_first, uop_last = 0.
  - uop_raA/raB/wa, uop_elem_cnt = 0.
  - in_ready=1 once rst deasserts.
- States: IDLE, ISSUE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready; all inputs are captured at that edge.
- Check at accept (illegal cases):
  - Illegal SEW, illegal LMUL, or any base register not a multiple of the group size G (G=1,2,4,8) -> err pulse next cycle, stay IDLE, no micro-ops.
  - Here "base register" means in_raA, in_raB or in_wa.
- Element counting:
  - VLMAX = G*(VLEN/SEW).
  - eff_vl = min(in_vl, VLMAX).
  - Number of micro-ops = ceil(eff_vl / (VLEN/SEW)), at most G.
- eff_vl = 0: accept, done pulse next cycle, no micro-ops, stay IDLE.
- Otherwise, go to ISSUE. uop_valid rises the cycle after accept (1-cycle latency).
- ISSUE, micro-op index i starting at 0:
  - uop_raA = base_A+i, uop_raB = base_B+i, uop_wa = base_wa+i.
  - uop_elem_cnt = min(remaining, VLEN/SEW).
  - uop_first = (i==0).
  - uop_last = (remaining <= VLEN/SEW).
- Handshake rules:
  - All uop_* outputs hold stable while uop_valid && !uop_ready.
  - On uop_valid && uop_ready: i++, remaining -= uop_elem_cnt, next micro-op presented the following cycle (back-to-back issue at 1/cycle with uop_ready=1).
- Completion:
  - Handshake of the micro-op with uop_last=1 -> uop_valid=0, done pulses next cycle, state -> IDLE.
  - in_ready=1 in the done cycle.
  - No new instruction is accepted in the same cycle as the last micro-op handshake.
- Register indices never exceed NREGS-1: the alignment check guarantees this, so there is no wrap.
- in_ready=0 throughout ISSUE; in_valid is ignored there.
- done and err are never both high.
- Arithmetic widths:
  - remaining: 8 bits.
  - VLMAX: up to 64 (fits 8 bits).
  - uop_elem_cnt max 8.
- Reset mid-ISSUE: immediate abort, all outputs to reset values, no done pulse.

Test Plan:
1. SEW enc 2 (32), LMUL enc 1 (G=2), vl=3, raA=4, raB=8, wa=12, uop_ready=1:
   - uop (4,8,12,cnt=2,first) next cycle.
   - Then uop (5,9,13,cnt=1,last).
   - done pulse following cycle.
2. Same instruction with uop_ready held 0 for 3 cycles on first micro-op -> outputs stable for 3 cycles; second micro-op only after the handshake; total 2 micro-ops.
3. SEW 8, LMUL 8, vl=200, bases 0/8/16 -> eff_vl=64, 8 micro-ops each cnt=8; last has uop_last=1; done once.
4. Each of the following -> err pulse next cycle, uop_valid never rises, in_ready stays 1:
   - LMUL 4 with raA=3.
   - SEW enc 5.
   - LMUL enc 4.
5. vl=0 (legal config) -> done pulse next cycle, zero micro-ops; fractional LMUL enc 6 with SEW 16 and vl=9 -> single micro-op cnt=4, first=last=1.
6. Assert rst low during second micro-op of scenario 3 -> all outputs 0 immediately, no done; after release a new instruction is accepted normally.
